// File: rtl/simon_frame_ctrl.sv
// simon_frame_ctrl
// Sits between the UART core's receive FIFO and the SIMON cipher core.
// A rising edge on frame_ready marks a complete 32-byte frame. Key, block and
// command are captured from it in that cycle. One cipher operation is then run
// with a start/done handshake, and the 64-bit result (or an ASCII error word) is
// handed back to the UART transmit FIFO with a one-cycle encrypt_end strobe.
//
// Ports
//   clk_100MHz       in   1    single clock
//   reset            in   1    synchronous, active-high
//   frame_ready      in   1    RX FIFO full flag; its rising edge marks a frame
//   frame_data       in   256  RX FIFO contents, byte k at [8k+7:8k]
//   cipher_start     out  1    one-cycle start pulse
//   cipher_decrypt   out  1    1 = decrypt, 0 = encrypt
//   cipher_key       out  128  frame bytes 0..15
//   cipher_block_in  out  64   frame bytes 16..23
//   cipher_done      in   1    one-cycle completion pulse
//   cipher_block_out in   64   cipher result, valid with cipher_done
//   write_data       out  64   word for the TX FIFO, held until the next load
//   encrypt_end      out  1    one-cycle TX FIFO load strobe
//   busy             out  1    high whenever the controller is not idle
//   overrun          out  1    sticky: a frame arrived while busy
module simon_frame_ctrl #(
  parameter int DBITS      = 8,
  parameter int FIFO_EXP   = 5,
  parameter int BLOCK_BITS = 64,
  parameter int KEY_BITS   = 128,
  parameter int TIMEOUT    = 4096,
  parameter int TO_BITS    = 13
) (
  input  logic                            clk_100MHz,
  input  logic                            reset,
  input  logic                            frame_ready,
  input  logic [DBITS*(2**FIFO_EXP)-1:0]  frame_data,
  output logic                            cipher_start,
  output logic                            cipher_decrypt,
  output logic [KEY_BITS-1:0]             cipher_key,
  output logic [BLOCK_BITS-1:0]           cipher_block_in,
  input  logic                            cipher_done,
  input  logic [BLOCK_BITS-1:0]           cipher_block_out,
  output logic [BLOCK_BITS-1:0]           write_data,
  output logic                            encrypt_end,
  output logic                            busy,
  output logic                            overrun
);

  localparam int FRAME_BITS = DBITS * (2**FIFO_EXP);
  localparam int CMD_LSB    = KEY_BITS + BLOCK_BITS;

  localparam logic [DBITS-1:0]      CMD_ENC = 8'h45;  // 'E'
  localparam logic [DBITS-1:0]      CMD_DEC = 8'h44;  // 'D'
  // "ERRCMD\r\n" / "ERRTMO\r\n", first character in the low byte
  localparam logic [BLOCK_BITS-1:0] ERR_CMD = 64'h0A0D_444D_4352_5245;
  localparam logic [BLOCK_BITS-1:0] ERR_TMO = 64'h0A0D_4F4D_5452_5245;
  localparam logic [TO_BITS-1:0]    TO_LAST = TO_BITS'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic                    frame_ready_r;
  logic                    frame_det_s;
  logic                    cmd_valid_s;
  logic [DBITS-1:0]        cmd_r;
  logic [KEY_BITS-1:0]     key_r;
  logic [BLOCK_BITS-1:0]   block_r;
  logic                    decrypt_r;
  logic                    start_r;
  logic [TO_BITS-1:0]      to_cnt_r;
  logic [BLOCK_BITS-1:0]   write_data_r;
  logic [BLOCK_BITS-1:0]   wd_next_s;
  logic                    encrypt_end_r;
  logic                    busy_r;
  logic                    overrun_r;
  logic                    unused_tail_s;

  // Frame bytes 25..31 carry nothing for this block.
  assign unused_tail_s = ^frame_data[FRAME_BITS-1:CMD_LSB+DBITS];

  assign frame_det_s = frame_ready & ~frame_ready_r;
  assign cmd_valid_s = (cmd_r == CMD_ENC) || (cmd_r == CMD_DEC);

  // Next-state decode and selection of the next TX word.
  always_comb begin
    next_state_s = state_r;
    wd_next_s    = write_data_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_det_s) begin
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (cmd_valid_s) begin
          next_state_s = ST_START;
        end else begin
          next_state_s = ST_ERROR;
          wd_next_s    = ERR_CMD;
        end
      end
      ST_START: begin
        next_state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A done pulse in the last allowed cycle still wins over the timeout.
        if (cipher_done) begin
          next_state_s = ST_RESULT;
          wd_next_s    = cipher_block_out;
        end else if (to_cnt_r == TO_LAST) begin
          next_state_s = ST_ERROR;
          wd_next_s    = ERR_TMO;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESULT, ST_ERROR: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Frame capture, timeout counter and registered outputs.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      frame_ready_r <= 1'b0;
      cmd_r         <= '0;
      key_r         <= '0;
      block_r       <= '0;
      decrypt_r     <= 1'b0;
      start_r       <= 1'b0;
      to_cnt_r      <= '0;
      write_data_r  <= '0;
      encrypt_end_r <= 1'b0;
      busy_r        <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      frame_ready_r <= frame_ready;
      if ((state_r == ST_IDLE) && frame_det_s) begin
        key_r   <= frame_data[KEY_BITS-1:0];
        block_r <= frame_data[KEY_BITS +: BLOCK_BITS];
        cmd_r   <= frame_data[CMD_LSB +: DBITS];
      end
      if ((state_r == ST_DECODE) && cmd_valid_s) begin
        decrypt_r <= (cmd_r == CMD_DEC);
      end
      if (state_r == ST_START) begin
        to_cnt_r <= '0;
      end else if (state_r == ST_WAIT) begin
        to_cnt_r <= to_cnt_r + TO_BITS'(1);
      end
      // Outputs are registered from the next state so they line up with it.
      start_r       <= (next_state_s == ST_START);
      write_data_r  <= wd_next_s;
      encrypt_end_r <= (next_state_s == ST_RESULT) || (next_state_s == ST_ERROR);
      busy_r        <= (next_state_s != ST_IDLE);
      if (frame_det_s && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign cipher_start    = start_r;
  assign cipher_decrypt  = decrypt_r;
  assign cipher_key      = key_r;
  assign cipher_block_in = block_r;
  assign write_data      = write_data_r;
  assign encrypt_end     = encrypt_end_r;
  assign busy            = busy_r;
  assign overrun         = overrun_r;

endmodule

// File: doc/simon_frame_ctrl.md
# simon_frame_ctrl

Control stage between the UART core's receive FIFO and the SIMON cipher core. It captures each 32-byte frame the UART core presents: 16 key bytes, 8 data bytes and a command byte. It then drives one cipher operation with a start/done handshake, and returns the 64-bit result (or an 8-byte ASCII error word) to the UART core's transmit FIFO as `write_data` plus a one-cycle `encrypt_end` load strobe.

## Interface
- `DBITS`, 8, bits per byte
- `FIFO_EXP`, 5, frame is `2**FIFO_EXP` bytes (fixed at 32 by the layout below)
- `BLOCK_BITS`, 64, cipher block width
- `KEY_BITS`, 128, cipher key width
- `TIMEOUT`, 4096, maximum cycles to wait for `cipher_done`
- `TO_BITS`, 13, timeout counter width (must satisfy `TIMEOUT < 2**TO_BITS`)

Ports:
- `clk_100MHz`, in, 1, the single clock
- `reset`, in, 1, synchronous, active-high
- `frame_ready`, in, 1, UART RX FIFO full flag (`rx_full`)
- `frame_data`, in, 256, UART `read_data`
- `cipher_start`, out, 1, one-cycle start pulse
- `cipher_decrypt`, out, 1, 1 = decrypt, 0 = encrypt; held while busy
- `cipher_key`, out, 128, held while busy
- `cipher_block_in`, out, 64, held while busy
- `cipher_done`, in, 1, one-cycle completion pulse
- `cipher_block_out`, in, 64, valid when `cipher_done` = 1
- `write_data`, out, 64, to UART `write_data`
- `encrypt_end`, out, 1, one-cycle load strobe to UART TX FIFO
- `busy`, out, 1, high in any state other than IDLE
- `overrun`, out, 1, sticky: a frame arrived while busy

## Operation
- **Frame layout:** byte k = `frame_data[8k+7:8k]`, with byte 0 the first byte received.
  - Key = bytes 0–15: `cipher_key` = `frame_data[127:0]`.
  - Block = bytes 16–23: `cipher_block_in` = `frame_data[191:128]`.
  - Byte 24 is the command: 0x45 'E' = encrypt, 0x44 'D' = decrypt, any other value is invalid.
  - Bytes 25–31 are ignored.
- **Frame detect:** on a rising edge of `frame_ready` (registered previous value 0, current value 1). Capture key, block and command from `frame_data` in that same cycle.
- **States:**
  - IDLE: on frame detect → DECODE.
  - DECODE: valid command → START and set `cipher_decrypt`; invalid command → ERROR with code CMD.
  - START: `cipher_start` = 1 for exactly this cycle; clear the timeout counter → WAIT.
  - WAIT: counter increments each cycle.
    - `cipher_done` → RESULT, latching `cipher_block_out`.
    - Counter reaches `TIMEOUT`-1 without `cipher_done` → ERROR with code TMO.
    - `cipher_done` takes priority over timeout in the same cycle.
  - RESULT: `write_data` ← latched result; `encrypt_end` = 1 → IDLE.
  - ERROR: `write_data` ← error word; `encrypt_end` = 1 → IDLE.
- **Error words** are transmitted byte 0 first, i.e. byte 0 sits at `write_data[7:0]`:
  - CMD: "ERRCMD\r\n" = 0x0A0D444D43525245
  - TMO: "ERRTMO\r\n" = 0x0A0D4F4D54525245
- **Frames while busy:** a frame detect in any state other than IDLE is dropped and sets `overrun`. Only `reset` clears `overrun`.
- **Late `cipher_done`:** a `cipher_done` arriving outside WAIT is ignored.
- **Output hold:** `write_data` holds its value until the next RESULT or ERROR.

## Timing
- **Reset values:** state IDLE; all outputs 0 (`cipher_*`, `write_data`, `encrypt_end`, `busy`, `overrun`); registered `frame_ready` = 0.
- **Reset mid-operation:** returns to IDLE within 1 cycle. No `encrypt_end` is issued for the aborted frame, and any later `cipher_done` is ignored.
- **Frame detect in cycle t:**
  - DECODE in cycle t+1.
  - `cipher_start` high in cycle t+2.
  - `busy` high from cycle t+1.
- **Successful operation:** `cipher_done` in cycle d → `write_data` updated and `encrypt_end` high in cycle d+1; IDLE (`busy` low) in cycle d+2.
- **Invalid command:** `encrypt_end` high in cycle t+2, with no `cipher_start`.
- **Timeout:** `encrypt_end` high `TIMEOUT`+1 cycles after `cipher_start`.
- **Back-to-back frames:** minimum frame-to-frame spacing for acceptance is 1 cycle after `busy` falls.

## Test plan
- **Encrypt:** send a frame with key bytes 0x00..0x0F, block bytes 0x10..0x17, command 'E'. Required:
  - `cipher_key` = 0x0F0E..0100.
  - `cipher_decrypt` = 0.
  - One `cipher_start` at t+2.
  - The model returns 0xDEADBEEFCAFEF00D → `write_data` equals it and one `encrypt_end` pulse at d+1.
- **Decrypt:** same frame with 'D' → `cipher_decrypt` = 1; round-trip the result through the model to recover block 0x1716151413121110.
- **Invalid command:** command 0x58 → no `cipher_start`; `write_data` = 0x0A0D444D43525245 and `encrypt_end` at t+2.
- **Timeout:** the model never asserts `cipher_done` → `encrypt_end` after `TIMEOUT`+1 cycles with `write_data` = 0x0A0D4F4D54525245. A `cipher_done` injected afterwards produces no further strobe.
- **Overrun:** pulse `frame_ready` again during WAIT → second frame ignored, `overrun` = 1, exactly one `encrypt_end`. A fresh frame after IDLE is processed normally.
- **Reset in WAIT:** assert `reset` for 1 cycle → all outputs 0, `busy` 0. A subsequent `cipher_done` causes no `encrypt_end`.
